// File: rtl/mips_pkg.sv
// Shared control-field bit positions and sizing defaults for the MIPS pipeline stages.
package mips_pkg;

    localparam int M_BRANCH      = 2;
    localparam int M_READ        = 1;
    localparam int M_WRITE       = 0;

    localparam int WB_REGW       = 1;
    localparam int WB_M2R        = 0;

    localparam int DEF_MEM_BYTES = 1024;

    function automatic logic is_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/data_mem.sv
// Byte-organised big-endian data memory: word-wide synchronous write, asynchronous word read.
module data_mem
    import mips_pkg::*;
#(
    parameter int MEM_BYTES = DEF_MEM_BYTES
) (
    input  logic                           clk_i,
    input  logic                           we_i,
    input  logic [$clog2(MEM_BYTES)-3:0]   waddr_i,
    input  logic [31:0]                    wdata_i,
    output logic [31:0]                    rdata_o
);

    localparam int AW = $clog2(MEM_BYTES);

    logic [7:0]    mem_q [MEM_BYTES];
    logic [AW-1:0] a0, a1, a2, a3;

    // Lowest address holds the most significant byte.
    assign a0 = {waddr_i, 2'd0};
    assign a1 = {waddr_i, 2'd1};
    assign a2 = {waddr_i, 2'd2};
    assign a3 = {waddr_i, 2'd3};

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[a0] <= wdata_i[31:24];
            mem_q[a1] <= wdata_i[23:16];
            mem_q[a2] <= wdata_i[15:8];
            mem_q[a3] <= wdata_i[7:0];
        end
    end

    assign rdata_o = {mem_q[a0], mem_q[a1], mem_q[a2], mem_q[a3]};

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: branch resolution, data memory access and the MEM/WB pipeline register.
module mem_stage
    import mips_pkg::*;
#(
    parameter int MEM_BYTES = DEF_MEM_BYTES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  in_M,
    input  logic [1:0]  in_WB,
    input  logic [31:0] in_add,
    input  logic        in_flag,
    input  logic [31:0] in_res,
    input  logic [31:0] in_dat2,
    input  logic [4:0]  in_mux,
    output logic        ou_pcsrc,
    output logic [31:0] ou_badd,
    output logic [1:0]  ou_WB,
    output logic [31:0] ou_rdat,
    output logic [31:0] ou_res,
    output logic [4:0]  ou_mux,
    output logic        ou_err
);

    localparam int AW = $clog2(MEM_BYTES);

    logic        aligned;
    logic        access;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [1:0]  wb_d,   wb_q;
    logic [31:0] rdat_d, rdat_q;
    logic [31:0] res_d,  res_q;
    logic [4:0]  mux_d,  mux_q;
    logic        err_d,  err_q;

    // Branch decision is not gated by reset so fetch sees it immediately.
    assign ou_pcsrc = in_M[M_BRANCH] & in_flag;
    assign ou_badd  = in_add;

    assign aligned = is_aligned(in_res[1:0]);
    assign access  = in_M[M_READ] | in_M[M_WRITE];
    assign mem_we  = in_M[M_WRITE] & aligned & ~rst;

    data_mem #(
        .MEM_BYTES (MEM_BYTES)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (in_res[AW-1:2]),
        .wdata_i (in_dat2),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        err_d          = access & ~aligned;
        rdat_d         = (in_M[M_READ] & aligned) ? mem_rdata : 32'd0;
        res_d          = in_res;
        mux_d          = in_mux;
        wb_d           = in_WB;
        // A faulting access must never retire a register write.
        wb_d[WB_REGW]  = in_WB[WB_REGW] & ~err_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q   <= 2'd0;
            rdat_q <= 32'd0;
            res_q  <= 32'd0;
            mux_q  <= 5'd0;
            err_q  <= 1'b0;
        end else begin
            wb_q   <= wb_d;
            rdat_q <= rdat_d;
            res_q  <= res_d;
            mux_q  <= mux_d;
            err_q  <= err_d;
        end
    end

    assign ou_WB   = wb_q;
    assign ou_rdat = rdat_q;
    assign ou_res  = res_q;
    assign ou_mux  = mux_q;
    assign ou_err  = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: byte-level memory model plus per-cycle expected-output queue.
module tb_mem_stage;

    localparam int MB = 1024;

    logic        clk;
    logic        rst;
    logic [2:0]  in_M;
    logic [1:0]  in_WB;
    logic [31:0] in_add;
    logic        in_flag;
    logic [31:0] in_res;
    logic [31:0] in_dat2;
    logic [4:0]  in_mux;
    logic        ou_pcsrc;
    logic [31:0] ou_badd;
    logic [1:0]  ou_WB;
    logic [31:0] ou_rdat;
    logic [31:0] ou_res;
    logic [4:0]  ou_mux;
    logic        ou_err;

    mem_stage #(
        .MEM_BYTES (MB)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_M     (in_M),
        .in_WB    (in_WB),
        .in_add   (in_add),
        .in_flag  (in_flag),
        .in_res   (in_res),
        .in_dat2  (in_dat2),
        .in_mux   (in_mux),
        .ou_pcsrc (ou_pcsrc),
        .ou_badd  (ou_badd),
        .ou_WB    (ou_WB),
        .ou_rdat  (ou_rdat),
        .ou_res   (ou_res),
        .ou_mux   (ou_mux),
        .ou_err   (ou_err)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // scoreboard
    int n_total = 0;
    int n_bad   = 0;
    logic [71:0] exp_q[$];
    logic [7:0]  mdl [MB];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mdl_rd(input logic [9:0] a);
        logic [9:0] b;
        b = {a[9:2], 2'b00};
        return {mdl[b], mdl[b + 10'd1], mdl[b + 10'd2], mdl[b + 10'd3]};
    endfunction

    // driver: apply one cycle of inputs, check comb outputs, predict and check registered outputs
    task automatic step(input logic r, input logic [2:0] m, input logic [1:0] wb,
                        input logic [31:0] addb, input logic fl, input logic [31:0] res,
                        input logic [31:0] d2, input logic [4:0] mux);
        logic        al, acc, e_err;
        logic [31:0] e_rd;
        logic [1:0]  e_wb;
        logic [9:0]  idx;
        logic [71:0] e, got;
        rst = r; in_M = m; in_WB = wb; in_add = addb; in_flag = fl;
        in_res = res; in_dat2 = d2; in_mux = mux;
        #1;
        check("pcsrc", {31'd0, ou_pcsrc}, {31'd0, m[2] & fl});
        check("badd", ou_badd, addb);

        idx   = res[9:0];
        al    = (res[1:0] == 2'b00);
        acc   = m[1] | m[0];
        e_err = !r && acc && !al;
        e_rd  = (!r && m[1] && al) ? mdl_rd(idx) : 32'd0;
        e_wb  = r ? 2'b00 : {wb[1] & ~e_err, wb[0]};
        e     = {e_wb, e_rd, (r ? 32'd0 : res), (r ? 5'd0 : mux), e_err};
        exp_q.push_back(e);
        if (!r && m[0] && al) begin
            mdl[idx]         = d2[31:24];
            mdl[idx + 10'd1] = d2[23:16];
            mdl[idx + 10'd2] = d2[15:8];
            mdl[idx + 10'd3] = d2[7:0];
        end

        @(posedge clk);
        #1;
        got = {ou_WB, ou_rdat, ou_res, ou_mux, ou_err};
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("wb",   {30'd0, got[71:70]}, {30'd0, e[71:70]});
            check("rdat", got[69:38], e[69:38]);
            check("res",  got[37:6],  e[37:6]);
            check("mux",  {27'd0, got[5:1]}, {27'd0, e[5:1]});
            check("err",  {31'd0, got[0]},   {31'd0, e[0]});
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        step(1'b0, 3'b001, 2'b00, 32'd0, 1'b0, a, d, 5'd0);
    endtask

    task automatic load(input logic [31:0] a, input logic [4:0] rd);
        step(1'b0, 3'b010, 2'b11, 32'd0, 1'b0, a, 32'd0, rd);
    endtask

    initial begin
        rst = 1'b1; in_M = 3'b000; in_WB = 2'b00; in_add = 32'd0; in_flag = 1'b0;
        in_res = 32'd0; in_dat2 = 32'd0; in_mux = 5'd0;

        // reset with busy inputs: outputs zero, no writes
        step(1'b1, 3'b111, 2'b11, 32'h1234, 1'b1, 32'h55, 32'hFFFF_FFFF, 5'd31);
        step(1'b1, 3'b011, 2'b10, 32'h0, 1'b0, 32'h8, 32'h1, 5'd7);

        // store then load, big-endian byte layout
        store(32'h10, 32'hDEAD_BEEF);
        check("byte_0x10", {24'd0, u_dut.u_mem.mem_q[16]}, 32'h0000_00DE);
        check("byte_0x13", {24'd0, u_dut.u_mem.mem_q[19]}, 32'h0000_00EF);
        load(32'h10, 5'd3);
        check("load_0x10", ou_rdat, 32'hDEAD_BEEF);

        // branch resolution is combinational
        step(1'b0, 3'b100, 2'b00, 32'h40, 1'b1, 32'h0, 32'h0, 5'd0);
        step(1'b0, 3'b100, 2'b00, 32'h40, 1'b0, 32'h0, 32'h0, 5'd0);

        // misaligned store: no write, err pulse, reg_write dropped
        step(1'b0, 3'b001, 2'b11, 32'h0, 1'b0, 32'h12, 32'hCAFE_F00D, 5'd9);
        check("mis_err", {31'd0, ou_err}, 32'd1);
        check("mis_wb", {30'd0, ou_WB}, 32'd1);
        step(1'b0, 3'b000, 2'b00, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0);
        check("mis_err_clr", {31'd0, ou_err}, 32'd0);
        load(32'h10, 5'd4);
        check("mis_nowrite", ou_rdat, 32'hDEAD_BEEF);
        load(32'h13, 5'd4);

        // address wrap
        store(32'h400, 32'h1234_5678);
        load(32'h000, 5'd5);
        check("wrap", ou_rdat, 32'h1234_5678);

        // read and write together returns old data
        store(32'h20, 32'h1);
        step(1'b0, 3'b011, 2'b10, 32'h0, 1'b0, 32'h20, 32'h2, 5'd6);
        check("rw_old", ou_rdat, 32'h1);
        load(32'h20, 5'd6);
        check("rw_new", ou_rdat, 32'h2);

        // reset during a store
        store(32'h30, 32'hAAAA_5555);
        step(1'b1, 3'b001, 2'b11, 32'h0, 1'b0, 32'h30, 32'hBBBB_0000, 5'd8);
        check("rst_res", ou_res, 32'd0);
        load(32'h30, 5'd8);
        check("rst_nowrite", ou_rdat, 32'hAAAA_5555);

        // prefill a small window, then random traffic over it
        for (int i = 0; i < 16; i++) store(32'(i * 4), $urandom());
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = ($urandom() & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            step(($urandom_range(0, 15) == 0), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 $urandom(), 1'($urandom_range(0, 1)), a, $urandom(), 5'($urandom_range(0, 31)));
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
